// File: rtl/fm_spi_cfg_seq_if.sv
// Command-word handshake between fm_spi_cfg_seq and its requesters / the SPI master FIFO.
// The sequencer uses the master modport; the environment uses slave.
interface fm_spi_cfg_seq_if #(
  parameter int DW = 24
);
  logic          init_req;
  logic          tune_req;
  logic [DW-1:0] tune_word;
  logic          fifo_full;
  logic [DW-1:0] spi_data_FIFO;
  logic          ena_write;
  logic          busy;
  logic          init_done;
  logic          tune_ack;
  logic          tune_ovr;

  modport master (
    input  init_req, tune_req, tune_word, fifo_full,
    output spi_data_FIFO, ena_write, busy, init_done, tune_ack, tune_ovr
  );

  modport slave (
    output init_req, tune_req, tune_word, fifo_full,
    input  spi_data_FIFO, ena_write, busy, init_done, tune_ack, tune_ovr
  );
endinterface

// File: rtl/fm_spi_cfg_seq.sv
// FM tuner SPI configuration sequencer: replays the init table and forwards tune words
// into the SPI master FIFO. Define SPI_CFG_GAP_EN to insert GAP_CYCLES idle cycles per word.
module fm_spi_cfg_seq #(
  parameter int DW         = 24,
  parameter int NUM_INIT   = 6,
  parameter int GAP_CYCLES = 64
) (
  input  logic             clk,
  input  logic             RSTn,
  fm_spi_cfg_seq_if.master bus
);

`ifdef SPI_CFG_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  // Gap state is left when the counter reaches this value; 0 gives a single-cycle gap.
  localparam logic [7:0] GAP_LAST = GAP_EN ? 8'(GAP_CYCLES) : 8'd0;
  localparam logic [3:0] IDX_LAST = 4'(NUM_INIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INIT_WR = 2'd1,
    ST_TUNE_WR = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          init_pend_r;
  logic          tune_pend_r;
  logic          run_init_r;
  logic          init_done_r;
  logic          tune_ovr_r;
  logic [3:0]    idx_r;
  logic [7:0]    gap_cnt_r;
  logic [DW-1:0] tune_buf_r;
  logic [DW-1:0] data_r;
  logic          write_s;
  logic          tune_write_s;
  logic          gap_done_s;
  logic          last_word_s;
  logic          start_init_s;
  logic          start_tune_s;
  logic          next_init_s;

  function automatic logic [DW-1:0] rom_word(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_word = DW'(24'h000000);
      4'd1:    rom_word = DW'(24'h0A0021);
      4'd2:    rom_word = DW'(24'h110482);
      4'd3:    rom_word = DW'(24'h2B1203);
      4'd4:    rom_word = DW'(24'h300004);
      4'd5:    rom_word = DW'(24'h4F0005);
      default: rom_word = {DW{1'b0}};
    endcase
  endfunction

  // Acceptance is gated by the live full flag so a write can never coincide with full.
  assign write_s      = ((state_r == ST_INIT_WR) || (state_r == ST_TUNE_WR)) && !bus.fifo_full;
  assign tune_write_s = write_s && (state_r == ST_TUNE_WR);
  assign gap_done_s   = (gap_cnt_r == GAP_LAST);
  assign last_word_s  = (idx_r == IDX_LAST);
  assign start_init_s = (state_r == ST_IDLE) && (state_nxt_s == ST_INIT_WR);
  assign start_tune_s = (state_r == ST_IDLE) && (state_nxt_s == ST_TUNE_WR);
  assign next_init_s  = (state_r == ST_GAP)  && (state_nxt_s == ST_INIT_WR);

  // State register
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; init has priority over a pending tune word
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (init_pend_r) begin
          state_nxt_s = ST_INIT_WR;
        end else if (tune_pend_r) begin
          state_nxt_s = ST_TUNE_WR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_INIT_WR, ST_TUNE_WR: begin
        if (!bus.fifo_full) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_GAP: begin
        if (!gap_done_s) begin
          state_nxt_s = ST_GAP;
        end else if (run_init_r && !last_word_s) begin
          state_nxt_s = ST_INIT_WR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ena_write     = write_s;
    bus.tune_ack      = tune_write_s;
    bus.busy          = (state_r != ST_IDLE);
    bus.spi_data_FIFO = data_r;
    bus.init_done     = init_done_r;
    bus.tune_ovr      = tune_ovr_r;
  end

  // Request latching, sequencing counters and the registered data word
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      init_pend_r <= 1'b0;
      tune_pend_r <= 1'b0;
      run_init_r  <= 1'b0;
      init_done_r <= 1'b0;
      tune_ovr_r  <= 1'b0;
      idx_r       <= 4'd0;
      gap_cnt_r   <= 8'd0;
      tune_buf_r  <= {DW{1'b0}};
      data_r      <= {DW{1'b0}};
    end else begin
      if (bus.init_req) begin
        init_pend_r <= 1'b1;
      end else if (start_init_s) begin
        init_pend_r <= 1'b0;
      end else begin
        init_pend_r <= init_pend_r;
      end

      // A word written this cycle is not overwritten, so a new request there is no overrun.
      if (bus.tune_req) begin
        tune_buf_r  <= bus.tune_word;
        tune_pend_r <= 1'b1;
      end else if (tune_write_s) begin
        tune_pend_r <= 1'b0;
      end else begin
        tune_pend_r <= tune_pend_r;
      end
      tune_ovr_r <= bus.tune_req && tune_pend_r && !tune_write_s;

      if (bus.init_req) begin
        init_done_r <= 1'b0;
      end else if ((state_r == ST_GAP) && gap_done_s && run_init_r && last_word_s) begin
        init_done_r <= 1'b1;
      end else begin
        init_done_r <= init_done_r;
      end

      if (start_init_s) begin
        idx_r      <= 4'd0;
        run_init_r <= 1'b1;
      end else if (start_tune_s) begin
        idx_r      <= idx_r;
        run_init_r <= 1'b0;
      end else if (next_init_s) begin
        idx_r      <= idx_r + 4'd1;
        run_init_r <= run_init_r;
      end else begin
        idx_r      <= idx_r;
        run_init_r <= run_init_r;
      end

      if (write_s) begin
        gap_cnt_r <= 8'd0;
      end else if ((state_r == ST_GAP) && !gap_done_s) begin
        gap_cnt_r <= gap_cnt_r + 8'd1;
      end else begin
        gap_cnt_r <= gap_cnt_r;
      end

      // The word to send is staged on entry to a write state, ready when ena_write rises.
      if (start_init_s) begin
        data_r <= rom_word(4'd0);
      end else if (next_init_s) begin
        data_r <= rom_word(idx_r + 4'd1);
      end else if (start_tune_s) begin
        data_r <= bus.tune_req ? bus.tune_word : tune_buf_r;
      end else if ((state_r == ST_TUNE_WR) && bus.fifo_full && bus.tune_req) begin
        data_r <= bus.tune_word;
      end else begin
        data_r <= data_r;
      end
    end
  end

endmodule
